// File: rtl/serial_sub_pkg.sv
// Shared types and constants for the bit-serial subtractor controller.
package serial_sub_pkg;

    // Controller states: waiting for a request, shifting bits, holding a result.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/serial_sub_if.sv
// Request/result bundle between a requester and serial_sub_ctrl.
// Optional flag outputs (zero, ovf) exist only when SERIAL_SUB_FLAGS_EN is defined.
//
// Handshake: a request is accepted on a rising edge where start=1 and
// in_ready=1; a result is consumed on a rising edge where out_valid=1 and
// out_ack=1. Neither start nor out_ack has any effect outside those edges.
interface serial_sub_if
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             in_ready;
    logic             busy;
    logic             out_valid;
    logic             out_ack;
    logic [WIDTH-1:0] d;
    logic             bout;
    state_t           state;     // controller state, for observation only
`ifdef SERIAL_SUB_FLAGS_EN
    logic             zero;
    logic             ovf;
`endif

    modport master (
        output start, a, b, bin, out_ack,
        input  in_ready, busy, out_valid, d, bout, state
`ifdef SERIAL_SUB_FLAGS_EN
        , input zero, ovf
`endif
    );

    modport slave (
        input  start, a, b, bin, out_ack,
        output in_ready, busy, out_valid, d, bout, state
`ifdef SERIAL_SUB_FLAGS_EN
        , output zero, ovf
`endif
    );

endinterface

// File: rtl/serial_sub_fs_cell.sv
// 1-bit full subtractor: d = a - b - bin, bout set when the bit borrows.
module fs_cell (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    // Purely combinational cell; the controller holds the borrow between bits.
    always_comb begin
        d    = a ^ b ^ bin;
        bout = (~a & b) | (~(a ^ b) & bin);
    end

endmodule

// File: rtl/serial_sub_ctrl.sv
// Bit-serial subtraction controller: one fs_cell processes the operands
// LSB-first over WIDTH cycles, then the result is held until acknowledged.
// Optional zero/ovf flags are built when SERIAL_SUB_FLAGS_EN is defined.
module serial_sub_ctrl
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic        clk,
    input  logic        rst_n,
    serial_sub_if.slave bus
);

    localparam int               CNT_W    = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] d_sh;
    logic             borrow;
    logic [CNT_W-1:0] cnt;
    logic             in_ready_q;
    logic             busy_q;
    logic             out_valid_q;
    logic [WIDTH-1:0] d_q;
    logic             bout_q;

    logic             cell_d;
    logic             cell_bout;
    logic [WIDTH:0]   d_cat;
    logic [WIDTH-1:0] d_next;

`ifdef SERIAL_SUB_FLAGS_EN
    logic nz_acc;   // set once any difference bit so far was 1
    logic zero_q;
    logic ovf_q;
`endif

    fs_cell u_cell (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .bin  (borrow),
        .d    (cell_d),
        .bout (cell_bout)
    );

    // New difference bit enters at the MSB; written this way so WIDTH=1 works.
    always_comb begin
        d_cat  = {cell_d, d_sh};
        d_next = d_cat[WIDTH:1];
    end

    // Controller FSM with its datapath registers and registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            a_sh        <= '0;
            b_sh        <= '0;
            d_sh        <= '0;
            borrow      <= 1'b0;
            cnt         <= '0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            d_q         <= '0;
            bout_q      <= 1'b0;
`ifdef SERIAL_SUB_FLAGS_EN
            nz_acc      <= 1'b0;
            zero_q      <= 1'b0;
            ovf_q       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        a_sh       <= bus.a;
                        b_sh       <= bus.b;
                        d_sh       <= '0;
                        borrow     <= bus.bin;
                        cnt        <= '0;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        state      <= RUN;
`ifdef SERIAL_SUB_FLAGS_EN
                        nz_acc     <= 1'b0;
`endif
                    end
                end
                RUN: begin
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    d_sh   <= d_next;
                    borrow <= cell_bout;
                    cnt    <= cnt + 1'b1;
`ifdef SERIAL_SUB_FLAGS_EN
                    nz_acc <= nz_acc | cell_d;
`endif
                    if (cnt == LAST_BIT) begin
                        // Final bit: publish the completed result.
                        d_q         <= d_next;
                        bout_q      <= cell_bout;
                        busy_q      <= 1'b0;
                        out_valid_q <= 1'b1;
                        state       <= DONE;
`ifdef SERIAL_SUB_FLAGS_EN
                        zero_q      <= ~(nz_acc | cell_d);
                        // Signed overflow: borrow into the MSB differs from borrow out of it.
                        ovf_q       <= borrow ^ cell_bout;
`endif
                    end
                end
                DONE: begin
                    // start is deliberately ignored here, even together with out_ack.
                    if (bus.out_ack) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state       <= IDLE;
`ifdef SERIAL_SUB_FLAGS_EN
                        zero_q      <= 1'b0;
                        ovf_q       <= 1'b0;
`endif
                    end
                end
                default: begin
                    in_ready_q  <= 1'b1;
                    busy_q      <= 1'b0;
                    out_valid_q <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.busy      = busy_q;
    assign bus.out_valid = out_valid_q;
    assign bus.d         = d_q;
    assign bus.bout      = bout_q;
    assign bus.state     = state;
`ifdef SERIAL_SUB_FLAGS_EN
    assign bus.zero      = zero_q;
    assign bus.ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Directed testbench for serial_sub_ctrl at WIDTH=8.
// Flag checks are compiled in when SERIAL_SUB_FLAGS_EN is defined.
module tb_serial_sub_ctrl;
    import serial_sub_pkg::*;

    localparam int W = 8;

    logic clk;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    serial_sub_if #(.WIDTH(W)) bus ();

    serial_sub_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Clock generation.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Absolute time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Present operands with start=1 and let the next edge accept them.
    task automatic do_accept(input logic [W-1:0] a_v, input logic [W-1:0] b_v, input logic bin_v);
        bus.a     = a_v;
        bus.b     = b_v;
        bus.bin   = bin_v;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    // Count edges from the accepting edge until out_valid, bounded.
    task automatic wait_done(output int lat);
        lat = 0;
        while (!bus.out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    // One-cycle acknowledge pulse.
    task automatic do_ack();
        bus.out_ack = 1'b1;
        @(posedge clk); #1;
        bus.out_ack = 1'b0;
    endtask

    task automatic test_reset();
        rst_n       = 1'b0;
        bus.start   = 1'b0;
        bus.a       = '0;
        bus.b       = '0;
        bus.bin     = 1'b0;
        bus.out_ack = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
        checks++; if (bus.d !== 8'h00) begin errors++; $display("FAIL reset_d: got %h want 00", bus.d); end
        checks++; if (bus.bout !== 1'b0) begin errors++; $display("FAIL reset_bout: got %b want 0", bus.bout); end
        checks++; if (bus.state !== IDLE) begin errors++; $display("FAIL reset_state: got %0d want %0d", bus.state, IDLE); end
`ifdef SERIAL_SUB_FLAGS_EN
        checks++; if ({bus.zero, bus.ovf} !== 2'b00) begin errors++; $display("FAIL reset_flags: got %b want 00", {bus.zero, bus.ovf}); end
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    // Basic vectors issued back to back (accept right after each ack).
    task automatic test_basic();
        logic [W-1:0] va [3];
        logic [W-1:0] vb [3];
        logic         vbin [3];
        logic [W-1:0] ed [3];
        logic         eb [3];
        int           lat;
        va = '{8'h05, 8'h03, 8'h00};
        vb = '{8'h03, 8'h05, 8'h00};
        vbin = '{1'b0, 1'b0, 1'b1};
        ed = '{8'h02, 8'hFE, 8'hFF};
        eb = '{1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 3; i++) begin
            checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL basic_ready[%0d]: got %b want 1", i, bus.in_ready); end
            do_accept(va[i], vb[i], vbin[i]);
            checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL basic_busy[%0d]: got %b want 1", i, bus.busy); end
`ifdef SERIAL_SUB_FLAGS_EN
            checks++; if ({bus.zero, bus.ovf} !== 2'b00) begin errors++; $display("FAIL basic_flags_run[%0d]: got %b want 00", i, {bus.zero, bus.ovf}); end
`endif
            wait_done(lat);
            checks++; if (lat !== W) begin errors++; $display("FAIL basic_latency[%0d]: got %0d want %0d", i, lat, W); end
            checks++; if (bus.d !== ed[i]) begin errors++; $display("FAIL basic_d[%0d]: got %h want %h", i, bus.d, ed[i]); end
            checks++; if (bus.bout !== eb[i]) begin errors++; $display("FAIL basic_bout[%0d]: got %b want %b", i, bus.bout, eb[i]); end
`ifdef SERIAL_SUB_FLAGS_EN
            checks++; if ({bus.zero, bus.ovf} !== 2'b00) begin errors++; $display("FAIL basic_flags[%0d]: got %b want 00", i, {bus.zero, bus.ovf}); end
`endif
            do_ack();
            checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL basic_ack[%0d]: got out_valid %b want 0", i, bus.out_valid); end
        end
    endtask

`ifdef SERIAL_SUB_FLAGS_EN
    task automatic test_flags();
        int lat;
        do_accept(8'h80, 8'h01, 1'b0);
        wait_done(lat);
        checks++; if (bus.d !== 8'h7F) begin errors++; $display("FAIL flags_ovf_d: got %h want 7f", bus.d); end
        checks++; if (bus.bout !== 1'b0) begin errors++; $display("FAIL flags_ovf_bout: got %b want 0", bus.bout); end
        checks++; if ({bus.zero, bus.ovf} !== 2'b01) begin errors++; $display("FAIL flags_ovf: got zero/ovf %b want 01", {bus.zero, bus.ovf}); end
        do_ack();
        checks++; if ({bus.zero, bus.ovf} !== 2'b00) begin errors++; $display("FAIL flags_idle: got %b want 00", {bus.zero, bus.ovf}); end
        do_accept(8'h05, 8'h05, 1'b0);
        wait_done(lat);
        checks++; if (bus.d !== 8'h00) begin errors++; $display("FAIL flags_zero_d: got %h want 00", bus.d); end
        checks++; if ({bus.zero, bus.ovf} !== 2'b10) begin errors++; $display("FAIL flags_zero: got zero/ovf %b want 10", {bus.zero, bus.ovf}); end
        do_ack();
    endtask
`endif

    // start pulsed and operands scrambled every RUN cycle must be ignored.
    task automatic test_ignore_during_run();
        int busy_n;
        int lat;
        do_accept(8'h05, 8'h03, 1'b0);
        busy_n = 0;
        lat    = 0;
        while (!bus.out_valid && lat < 40) begin
            if (bus.busy) busy_n++;
            bus.start = 1'b1;
            bus.a     = 8'($urandom_range(0, 255));
            bus.b     = 8'($urandom_range(0, 255));
            bus.bin   = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            lat++;
        end
        bus.start = 1'b0;
        checks++; if (busy_n !== W) begin errors++; $display("FAIL ignore_busy_cycles: got %0d want %0d", busy_n, W); end
        checks++; if (lat !== W) begin errors++; $display("FAIL ignore_latency: got %0d want %0d", lat, W); end
        checks++; if (bus.d !== 8'h02) begin errors++; $display("FAIL ignore_d: got %h want 02", bus.d); end
        checks++; if (bus.bout !== 1'b0) begin errors++; $display("FAIL ignore_bout: got %b want 0", bus.bout); end
        do_ack();
    endtask

    // Result held while ack is withheld; start together with ack starts nothing.
    task automatic test_hold_and_ack();
        int lat;
        do_accept(8'h03, 8'h05, 1'b0);
        wait_done(lat);
        for (int k = 0; k < 5; k++) begin
            checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL hold_valid[%0d]: got %b want 1", k, bus.out_valid); end
            checks++; if (bus.d !== 8'hFE) begin errors++; $display("FAIL hold_d[%0d]: got %h want fe", k, bus.d); end
            checks++; if (bus.bout !== 1'b1) begin errors++; $display("FAIL hold_bout[%0d]: got %b want 1", k, bus.bout); end
            @(posedge clk); #1;
        end
        bus.a       = 8'h11;
        bus.b       = 8'h22;
        bus.start   = 1'b1;
        bus.out_ack = 1'b1;
        @(posedge clk); #1;
        bus.start   = 1'b0;
        bus.out_ack = 1'b0;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL both_valid: got %b want 0", bus.out_valid); end
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL both_ready: got %b want 1", bus.in_ready); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL both_busy: got %b want 0", bus.busy); end
        @(posedge clk); #1;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL both_no_new_op: got busy %b want 0", bus.busy); end
        checks++; if (bus.d !== 8'hFE) begin errors++; $display("FAIL both_d_kept: got %h want fe", bus.d); end
        checks++; if (bus.bout !== 1'b1) begin errors++; $display("FAIL both_bout_kept: got %b want 1", bus.bout); end
    endtask

    // Reset asserted in the middle of RUN, then a clean operation.
    task automatic test_reset_mid_run();
        int lat;
        do_accept(8'h80, 8'h01, 1'b0);
        repeat (3) begin @(posedge clk); #1; end
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL midrst_busy_before: got %b want 1", bus.busy); end
        rst_n = 1'b0;
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready: got %b want 1", bus.in_ready); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b want 0", bus.busy); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b want 0", bus.out_valid); end
        checks++; if (bus.d !== 8'h00) begin errors++; $display("FAIL midrst_d: got %h want 00", bus.d); end
        checks++; if (bus.bout !== 1'b0) begin errors++; $display("FAIL midrst_bout: got %b want 0", bus.bout); end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        do_accept(8'h00, 8'h00, 1'b1);
        wait_done(lat);
        checks++; if (lat !== W) begin errors++; $display("FAIL midrst_latency: got %0d want %0d", lat, W); end
        checks++; if (bus.d !== 8'hFF) begin errors++; $display("FAIL midrst_d_after: got %h want ff", bus.d); end
        checks++; if (bus.bout !== 1'b1) begin errors++; $display("FAIL midrst_bout_after: got %b want 1", bus.bout); end
        do_ack();
    endtask

    initial begin
        test_reset();
        test_basic();
`ifdef SERIAL_SUB_FLAGS_EN
        test_flags();
`endif
        test_ignore_during_run();
        test_hold_and_ack();
        test_reset_mid_run();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/serial_sub_ctrl.md
# serial_sub_ctrl

Bit-serial subtraction controller: accepts two WIDTH-bit operands plus a borrow-in, drives one 1-bit full-subtractor cell LSB-first for WIDTH cycles with the borrow held in a flop, then presents difference and borrow-out until acknowledged. It lets one full-subtractor cell serve as a multi-bit subtractor in area-constrained lab datapaths, trading latency for gates.

## Interface
Parameters:
- WIDTH, 8, operand/result width in bits; legal range WIDTH ≥ 1.

Ports:
- clk  in  1  system clock, rising-edge active.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request; accepted only when in_ready=1.
- a  in  WIDTH  minuend, sampled on the accepting edge.
- b  in  WIDTH  subtrahend, sampled on the accepting edge.
- bin  in  1  borrow-in to bit 0, sampled on the accepting edge.
- in_ready  out  1  high in IDLE only.
- busy  out  1  high in RUN only.
- out_valid  out  1  high in DONE only.
- out_ack  in  1  consumer acknowledge, honoured only in DONE.
- d  out  WIDTH  difference a − b − bin mod 2^WIDTH.
- bout  out  1  final borrow-out.

## Operation
- States: IDLE, RUN, DONE.
- IDLE: start=1 → latch a, b into shift registers, borrow flop ← bin, bit counter ← 0, go RUN. start=0 → stay.
- RUN, each cycle: cell inputs = a_sh[0], b_sh[0], borrow; d_sh ← {cell_d, d_sh[WIDTH-1:1]}; a_sh, b_sh shift right; borrow ← cell_bout; counter++. When counter = WIDTH−1 on this edge → go DONE.
- DONE: d = d_sh, bout = borrow, both stable; out_ack=1 → go IDLE (d, bout keep last value).
- Cell equations: cell_d = a^b^bin; cell_bout = (~a & b) | (~(a^b) & bin).
- start outside IDLE ignored, not queued; operand changes outside accepting edge ignored.
- DONE with start=1 and out_ack=1 same cycle: ack taken, start ignored; requester must re-assert in IDLE.
- out_ack outside DONE ignored.
- Counter width $clog2(WIDTH+1); no wrap possible.

## Timing
- Reset (async assert, any state, incl. mid-RUN): state=IDLE, in_ready=1, busy=0, out_valid=0, d=0, bout=0, all shift regs, counter and borrow flop 0. Deassertion synchronous to clk by upstream; first accept possible on the first rising edge with rst_n=1.
- Latency: out_valid rises exactly WIDTH edges after the accepting edge; WIDTH=1 → next edge.
- Throughput: one operation per WIDTH+2 cycles minimum (accept, WIDTH RUN cycles, one DONE cycle with ack).
- out_valid held indefinitely until out_ack; no timeout.
- All outputs registered or decoded from state only; no combinational path start→in_ready or out_ack→out_valid.

## Configuration
- SERIAL_SUB_FLAGS_EN defined: extra outputs zero (1, d == 0) and ovf (1, signed two's-complement overflow of a − b − bin), registered, valid while out_valid=1, 0 at reset and in IDLE/RUN. zero tracked serially (OR of shifted-in bits); ovf = borrow-in-to-MSB XOR borrow-out-of-MSB, captured on the final RUN cycle.
- Undefined: ports zero and ovf absent; no extra flops.

## Structure
- Package serial_sub_pkg: state enum type (IDLE, RUN, DONE), default WIDTH constant.
- One sub-module: fs_cell, combinational 1-bit full subtractor (a, b, bin → d, bout); single instance.
- Controller FSM, counter, shift registers, borrow flop in serial_sub_ctrl.

## Test plan
- WIDTH=8, a=0x05, b=0x03, bin=0 → out_valid after 8 edges, d=0x02, bout=0; with flags zero=0, ovf=0.
- a=0x03, b=0x05, bin=0 → d=0xFE, bout=1; a=0x00, b=0x00, bin=1 → d=0xFF, bout=1.
- Flags: a=0x80, b=0x01, bin=0 → d=0x7F, bout=0, ovf=1; a=0x05, b=0x05 → d=0x00, zero=1.
- start pulsed and operands changed every cycle during RUN → ignored, result matches first accepted operands; busy=1 for exactly 8 cycles.
- out_ack withheld 5 cycles in DONE → out_valid, d, bout stable; start+out_ack together → IDLE, no new op started.
- rst_n low at RUN cycle 4 → all outputs 0, in_ready=1 immediately; next op after release gives correct result.
